matrix_scan_ctrl: RTL and testbench

Row-scanning controller for the 7-row x 5-column dot-matrix driven by the 3-bit pattern decoder. It drives the pattern code into the decoder and takes the decoder's 35-bit map back. It multiplexes the map onto the display one row at a time, with a blanking cycle between rows. In auto mode it steps through all 8 patterns; in manual mode it shows the externally selected pattern.

---
 rtl/matrix_scan_ctrl_pkg.sv | 26 ++
 rtl/matrix_scan_ctrl_scan_tick_counter.sv | 37 +++
 rtl/matrix_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the dot-matrix row scanner.
// Contents:
//   N_ROWS / N_COLS / MAP_W / CODE_W / ROW_W : geometry of the 7x5 matrix
//   state_t   : scanner FSM states (IDLE, BLANK, DRIVE)
//   map_slice : extracts the 5 column bits of one row from the decoder map
package matrix_scan_ctrl_pkg;

  localparam int N_ROWS = 7;
  localparam int N_COLS = 5;
  localparam int MAP_W  = N_ROWS * N_COLS;
  localparam int CODE_W = 3;
  localparam int ROW_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Bit 5*r+c of the map is row r, column c.
  function automatic logic [N_COLS-1:0] map_slice(input logic [MAP_W-1:0] map,
                                                  input logic [ROW_W-1:0] row);
    return map[N_COLS*row +: N_COLS];
  endfunction

endpackage

// File: rtl/matrix_scan_ctrl_scan_tick_counter.sv
// Down-counter with synchronous load and decrement enable, used for both the
// per-row tick count and the frames-per-pattern count.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (count <= RESET_VAL)
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one; the count holds at zero
//   o_tc         : terminal count, high while the count is zero
module scan_tick_counter
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scanning controller for a 7-row x 5-column dot matrix fed by a 3-bit
// pattern decoder. Each row is shown for TICKS_PER_ROW cycles, preceded by
// one blanking cycle; a frame is 7*(1+TICKS_PER_ROW) cycles. In auto mode the
// pattern code advances every FRAMES_PER_STEP frames, in manual mode the code
// follows sel. Mode and selection changes take effect only at frame ends.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : scan enable; low returns to IDLE (code and frame count kept)
//   auto       : 1 = auto-cycle patterns, 0 = show sel
//   sel        : manual pattern code {A,B,C}
//   map_in     : decoder map, bit 5*r+c = row r, column c
//   code       : pattern code to the decoder (registered)
//   row_n      : active-low row drive, at most one bit low (registered)
//   col        : active-high column data of the driven row (registered)
//   frame_done : one-cycle pulse after row 6 completes (registered)
//   dbg_state  : current FSM state, for observation only
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int TICKS_PER_ROW   = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              auto,
  input  logic [CODE_W-1:0] sel,
  input  logic [MAP_W-1:0]  map_in,
  output logic [CODE_W-1:0] code,
  output logic [N_ROWS-1:0] row_n,
  output logic [N_COLS-1:0] col,
  output logic              frame_done,
  output state_t            dbg_state
);

  localparam int TICK_W = (TICKS_PER_ROW   > 1) ? $clog2(TICKS_PER_ROW)   : 1;
  localparam int FRM_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  // Both counters count down to zero; the frame counter holds the number of
  // frames still to show at the current code, so "frame_cnt = 0" in up-count
  // terms corresponds to FRAMES_PER_STEP-1 here.
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_ROW - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FRAMES_PER_STEP - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(N_ROWS - 1);

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [N_ROWS-1:0]   r_row_n;
  logic [N_COLS-1:0]   r_col;
  logic [CODE_W-1:0]   r_code;
  logic                r_frame_done;

  state_t              w_state_nxt;
  logic [ROW_W-1:0]    w_row_nxt;
  logic [N_ROWS-1:0]   w_row_n_nxt;
  logic [N_COLS-1:0]   w_col_nxt;
  logic [CODE_W-1:0]   w_code_nxt;
  logic                w_frame_done_nxt;

  logic                w_tick_load;
  logic [TICK_W-1:0]   w_tick_load_val;
  logic                w_tick_dec;
  logic                w_tick_tc;
  logic                w_frm_load;
  logic                w_frm_dec;
  logic                w_frm_tc;

  scan_tick_counter #(
    .WIDTH     (TICK_W),
    .RESET_VAL ('0)
  ) u_tick_cnt (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tick_load),
    .i_load_val (w_tick_load_val),
    .i_dec      (w_tick_dec),
    .o_tc       (w_tick_tc)
  );

  scan_tick_counter #(
    .WIDTH     (FRM_W),
    .RESET_VAL (FRM_LAST)
  ) u_frame_cnt (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_frm_load),
    .i_load_val (FRM_LAST),
    .i_dec      (w_frm_dec),
    .o_tc       (w_frm_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_row_n      <= '1;
      r_col        <= '0;
      r_code       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_row_n      <= w_row_n_nxt;
      r_col        <= w_col_nxt;
      r_code       <= w_code_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_row_nxt        = r_row;
    w_row_n_nxt      = r_row_n;
    w_col_nxt        = r_col;
    w_code_nxt       = r_code;
    w_frame_done_nxt = 1'b0;
    w_tick_load      = 1'b0;
    w_tick_load_val  = '0;
    w_tick_dec       = 1'b0;
    w_frm_load       = 1'b0;
    w_frm_dec        = 1'b0;

    if (!en) begin
      w_state_nxt = IDLE;
      w_row_nxt   = '0;
      w_row_n_nxt = '1;
      w_col_nxt   = '0;
      w_tick_load = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_row_nxt   = '0;
          w_row_n_nxt = '1;
          w_col_nxt   = '0;
          if (!auto) begin
            w_code_nxt = sel;
          end
        end

        // The code changed at least one cycle ago, so map_in has settled.
        BLANK: begin
          w_state_nxt     = DRIVE;
          w_col_nxt       = map_slice(map_in, r_row);
          w_row_n_nxt     = ~(N_ROWS'(1) << r_row);
          w_tick_load     = 1'b1;
          w_tick_load_val = TICK_LAST;
        end

        DRIVE: begin
          if (w_tick_tc) begin
            w_state_nxt = BLANK;
            w_row_n_nxt = '1;
            w_col_nxt   = '0;
            if (r_row == ROW_LAST) begin
              w_row_nxt        = '0;
              w_frame_done_nxt = 1'b1;
              if (!auto) begin
                // Manual frames also restart the auto frame count, so a
                // later switch to auto begins counting from zero.
                w_code_nxt = sel;
                w_frm_load = 1'b1;
              end else if (w_frm_tc) begin
                w_code_nxt = r_code + 1'b1;
                w_frm_load = 1'b1;
              end else begin
                w_frm_dec = 1'b1;
              end
            end else begin
              w_row_nxt = r_row + 1'b1;
            end
          end else begin
            w_tick_dec = 1'b1;
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_row_nxt   = '0;
          w_row_n_nxt = '1;
          w_col_nxt   = '0;
        end
      endcase
    end
  end

  assign code       = r_code;
  assign row_n      = r_row_n;
  assign col        = r_col;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl at default parameters
// (TICKS_PER_ROW=4, FRAMES_PER_STEP=2, so one frame = 35 cycles).
// Inputs change 1 time unit after a rising edge; outputs are checked there
// and by a negedge monitor for the row/column blanking invariants.
module tb_matrix_scan_ctrl;
  import matrix_scan_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        auto;
  logic [2:0]  sel;
  logic [34:0] map_in;
  logic [2:0]  code;
  logic [6:0]  row_n;
  logic [4:0]  col;
  logic        frame_done;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on   = 1'b0;

  // {row_n, col, frame_done, code} expected per cycle of a frame
  logic [15:0] exp_q[$];

  matrix_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .auto       (auto),
    .sel        (sel),
    .map_in     (map_in),
    .code       (code),
    .row_n      (row_n),
    .col        (col),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check_eq("one_row_low", 64'($countones(~row_n) <= 1), 64'd1);
      if (dbg_state != DRIVE) check_eq("blank_row_n", row_n, 7'h7F);
      if (row_n == 7'h7F) check_eq("blank_col", col, 5'h00);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ramp_map();
    for (int r = 0; r < 7; r++) map_in[5*r +: 5] = 5'(r + 1);
  endtask

  // Checks one full frame starting with the edge that enters BLANK (j=0).
  // Row r is driven on cycles j=5r+1..5r+4; every other cycle is blank.
  task automatic frame_sb(input logic [2:0] exp_code, input bit first);
    logic [6:0]  e_row_n;
    logic [4:0]  e_col;
    logic        e_fd;
    logic [15:0] e;
    int          r;
    for (int j = 0; j < 35; j++) begin
      e_fd = (j == 0) && !first;
      if (j == 0 || ((j - 1) % 5) == 4) begin
        e_row_n = 7'h7F;
        e_col   = 5'h00;
      end else begin
        r       = (j - 1) / 5;
        e_row_n = ~(7'd1 << r);
        e_col   = 5'(r + 1);
      end
      exp_q.push_back({e_row_n, e_col, e_fd, exp_code});
    end
    for (int j = 0; j < 35; j++) begin
      step(1);
      e = exp_q.pop_front();
      check_eq($sformatf("frame_j%0d", j), {row_n, col, frame_done, code}, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    auto   = 1'b0;
    sel    = 3'd0;
    map_in = '0;
    step(2);
    check_eq("rst_row_n", row_n, 7'h7F);
    check_eq("rst_col", col, 5'h00);
    check_eq("rst_code", code, 3'd0);
    check_eq("rst_fd", frame_done, 1'b0);
    check_eq("rst_state", dbg_state, IDLE);
    rst    = 1'b0;
    mon_on = 1'b1;
    step(2);
    check_eq("idle_hold", dbg_state, IDLE);

    // Manual, sel=5, ramp map: first frame.
    load_ramp_map();
    sel = 3'd5;
    en  = 1'b1;
    frame_sb(3'd5, 1'b1);

    // Second frame by hand: sel change and map change mid-frame.
    step(1);
    check_eq("f2_fd", frame_done, 1'b1);
    check_eq("f2_code", code, 3'd5);
    step(16);
    check_eq("f2_row3_row_n", row_n, 7'b1110111);
    check_eq("f2_row3_col", col, 5'h04);
    sel = 3'd2;
    step(5);
    check_eq("f2_row4_col", col, 5'h05);
    map_in[20 +: 5] = 5'h1F;
    step(3);
    check_eq("f2_map_held", col, 5'h05);
    check_eq("f2_sel_held", code, 3'd5);
    load_ramp_map();
    step(10);
    check_eq("f2_row6_row_n", row_n, 7'b0111111);
    check_eq("f2_row6_col", col, 5'h07);
    check_eq("f2_code_end", code, 3'd5);
    frame_sb(3'd2, 1'b0);

    // Manual code 6, then auto: 6,6,7,7,0 (sel ignored in auto).
    sel = 3'd6;
    frame_sb(3'd6, 1'b0);
    auto = 1'b1;
    sel  = 3'd1;
    frame_sb(3'd6, 1'b0);
    frame_sb(3'd7, 1'b0);
    frame_sb(3'd7, 1'b0);
    frame_sb(3'd0, 1'b0);

    // en dropped at row 4, tick 1.
    step(1);
    check_eq("f9_code", code, 3'd0);
    check_eq("f9_fd", frame_done, 1'b1);
    step(22);
    check_eq("en_row4_row_n", row_n, 7'b1101111);
    check_eq("en_row4_col", col, 5'h05);
    en = 1'b0;
    step(1);
    check_eq("en_off_state", dbg_state, IDLE);
    check_eq("en_off_row_n", row_n, 7'h7F);
    check_eq("en_off_col", col, 5'h00);
    check_eq("en_off_fd", frame_done, 1'b0);
    check_eq("en_off_code", code, 3'd0);
    step(3);
    check_eq("en_off_hold", dbg_state, IDLE);
    en = 1'b1;
    frame_sb(3'd0, 1'b1);
    // Frame count was retained at 1 across the idle, so this frame end steps.
    step(1);
    check_eq("retained_cnt_code", code, 3'd1);
    check_eq("retained_cnt_fd", frame_done, 1'b1);

    // Asynchronous reset mid-DRIVE (row 3, tick 2).
    step(18);
    check_eq("pre_rst_row_n", row_n, 7'b1110111);
    check_eq("pre_rst_code", code, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_row_n", row_n, 7'h7F);
    check_eq("async_rst_col", col, 5'h00);
    check_eq("async_rst_code", code, 3'd0);
    check_eq("async_rst_fd", frame_done, 1'b0);
    check_eq("async_rst_state", dbg_state, IDLE);
    step(2);
    rst = 1'b0;
    step(1);
    check_eq("post_rst_state", dbg_state, BLANK);
    check_eq("post_rst_code", code, 3'd0);
    step(1);
    check_eq("post_rst_row_n", row_n, 7'b1111110);
    check_eq("post_rst_col", col, 5'h01);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
